instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001: Parameter SIZE, default 32, SHALL set the width of every address/PC port and register.
REQ-002: Parameter BASE_INSTRUCTION, default 32'h00000000, SHALL be the fetch address after reset.
REQ-003: Parameter DEPTH, default 2, SHALL set the instruction buffer entries and the maximum number of outstanding requests.
REQ-004: clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005: rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006: redirect_valid  input  1  SHALL request a fetch-stream change (branch/jump target from the PC stage).
REQ-007: redirect_pc  input  SIZE  SHALL give the new fetch address; bits [1:0] are ignored and treated as 0.
REQ-008: imem_req_valid  output  1  SHALL indicate a valid instruction-memory read request.
REQ-009: imem_req_addr  output  SIZE  SHALL carry the request address, equal to fetch_pc.
REQ-010: imem_req_ready  input  1  SHALL accept the request; a transfer occurs when valid and ready are both 1.
REQ-011: imem_rsp_valid / imem_rsp_data / imem_rsp_err  input  1/32/1  SHALL return one in-order response per accepted request, no earlier than the cycle after acceptance.
REQ-012: inst_valid / inst_data / inst_pc / inst_err  output  1/32/SIZE/1  SHALL present the oldest buffered instruction to decode.
REQ-013: inst_ready  input  1  SHALL consume the presented instruction when inst_valid is also 1.
REQ-014: fetch_pc  output  SIZE  SHALL expose the next address to be requested.

Function
REQ-015: States: RUN, DRAIN, HALT; from reset the state SHALL be RUN.
REQ-016: imem_req_valid SHALL be 1 only in RUN while (outstanding + buffer count) < DEPTH; the value SHALL not depend combinationally on imem_req_ready.
REQ-017: On each accepted request, fetch_pc SHALL advance by 4 modulo 2^SIZE (32'hFFFFFFFC wraps to 0), and the request address SHALL be queued as the pending PC.
REQ-018: Each non-dropped response SHALL be written into the buffer with {pending PC, data, err} and become visible on inst_* the next cycle (minimum request-accept-to-inst_valid latency 2 cycles).
REQ-019: Buffer order SHALL be FIFO; simultaneous write and read SHALL both take effect; the buffer can never overflow because of the REQ-016 credit rule.
REQ-020: inst_* outputs SHALL be registered and held stable while inst_valid=1 and inst_ready=0.
REQ-021: Redirect (any state): the buffer SHALL be flushed, fetch_pc SHALL load {redirect_pc[SIZE-1:2],2'b00} at the next edge, and the state SHALL become DRAIN if any request is outstanding after that edge, else RUN.
REQ-022: A request accepted in the redirect cycle SHALL count as outstanding and be dropped; a response arriving in the redirect cycle SHALL be dropped.
REQ-023: An inst handshake in the redirect cycle SHALL complete (that instruction counts as delivered); all other entries are discarded.
REQ-024: DRAIN SHALL issue no requests, discard every response, and return to RUN in the cycle after the last outstanding response is discarded.
REQ-025: A redirect during DRAIN SHALL update fetch_pc and remain in DRAIN.
REQ-026: After a buffer entry with err=1 is consumed, the state SHALL become HALT: no new requests; remaining outstanding responses are still buffered and delivered; exit only by redirect.
REQ-027: Outstanding count SHALL range 0..DEPTH and never underflow; a response with no outstanding request is a protocol violation and SHALL be ignored.

Reset
REQ-028: While rst=0: fetch_pc=BASE_INSTRUCTION, state=RUN, buffer and outstanding counts 0, imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, inst_err=0.
REQ-029: Reset asserted mid-operation SHALL drop all pending requests and buffered entries immediately; responses to pre-reset requests arriving after release are out of protocol.
REQ-030: The first request SHALL be presented in the first cycle after rst rises, with address BASE_INSTRUCTION.

Verification
REQ-031: Reset release, imem_req_ready=1, memory returns data one cycle later, inst_ready=1 -> inst_pc 0,4,8,... sequential, inst_valid first asserted 2 cycles after first accept.
REQ-032: inst_ready=0 with DEPTH=2 -> exactly 2 requests accepted, then imem_req_valid=0; inst_data stable; releasing inst_ready resumes requests.
REQ-033: Redirect to 32'h00000103 with 2 outstanding -> both responses discarded, DRAIN, next request address 32'h00000100, first inst_pc 32'h00000100.
REQ-034: Response with imem_rsp_err=1 at PC 0x8 -> inst_err=1 with inst_pc=0x8, no further requests until redirect.
REQ-035: Redirect_pc=32'hFFFFFFFC -> requests 32'hFFFFFFFC then 32'h00000000.
REQ-036: rst asserted while buffer full -> inst_valid and imem_req_valid 0 immediately; after release, first request address BASE_INSTRUCTION.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface instr_fetch_if #(
  parameter int SIZE = 32
);
  logic            imem_req_valid;
  logic [SIZE-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            imem_rsp_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
  );
endinterface

// File: rtl/instr_fetch.sv
// Credit-limited instruction fetch unit: issues sequential imem reads, buffers
// in-order responses for decode, and handles redirects, draining and error halt.
module instr_fetch #(
  parameter int              SIZE             = 32,
  parameter logic [SIZE-1:0] BASE_INSTRUCTION = SIZE'(32'h0000_0000),
  parameter int              DEPTH            = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [SIZE-1:0] redirect_pc,
  instr_fetch_if.master   imem,
  output logic            inst_valid,
  output logic [31:0]     inst_data,
  output logic [SIZE-1:0] inst_pc,
  output logic            inst_err,
  input  logic            inst_ready,
  output logic [SIZE-1:0] fetch_pc
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  typedef struct packed {
    logic [SIZE-1:0] pc;
    logic [31:0]     data;
    logic            err;
  } entry_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] pc_q, pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] pend_q [DEPTH];
  logic [SIZE-1:0] pend_d [DEPTH];
  entry_t          buf_q  [DEPTH];
  entry_t          buf_d  [DEPTH];

  logic        accept, rsp_take, buf_push, buf_pop;
  logic [CW:0] credit_used;
  entry_t      buf_wdata;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Credits count both in-flight requests and filled slots, so a response
  // always has a free buffer entry waiting for it.
  assign credit_used         = {1'b0, out_q} + {1'b0, cnt_q};
  assign imem.imem_req_valid = rst && (state_q == RUN) && (credit_used < DEPTH_W);
  assign imem.imem_req_addr  = pc_q;
  assign fetch_pc            = pc_q;

  assign accept   = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_take = imem.imem_rsp_valid && (out_q != '0);
  assign buf_push = rsp_take && !redirect_valid && (state_q != DRAIN);
  assign buf_pop  = inst_valid && inst_ready;

  assign inst_valid = (cnt_q != '0);
  assign inst_pc    = buf_q[0].pc;
  assign inst_data  = buf_q[0].data;
  assign inst_err   = buf_q[0].err;

  assign buf_wdata = '{pc: pend_q[0], data: imem.imem_rsp_data, err: imem.imem_rsp_err};

  // Both queues are shift registers with the head in slot 0, so the
  // inst_* outputs come straight from flops.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pend_d = pend_q;
    if (rsp_take) begin
      for (int i = 0; i < DEPTH - 1; i++) pend_d[i] = pend_q[i + 1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (int'(out_q) - int'(rsp_take) == i)) pend_d[i] = pc_q;
    end

    buf_d = buf_q;
    if (buf_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) buf_d[i] = buf_q[i + 1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (buf_push && (int'(cnt_q) - int'(buf_pop) == i)) buf_d[i] = buf_wdata;
    end
  end

  always_comb begin
    out_d = out_q + CW'(accept) - CW'(rsp_take);
    cnt_d = redirect_valid ? '0 : cnt_q + CW'(buf_push) - CW'(buf_pop);

    pc_d = pc_q;
    if (redirect_valid)  pc_d = {redirect_pc[SIZE-1:2], 2'b00};
    else if (accept)     pc_d = pc_q + SIZE'(4);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (buf_pop && buf_q[0].err) state_d = HALT;
      DRAIN:   if (out_d == '0)             state_d = RUN;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    // A redirect overrides everything; stay in DRAIN while stale responses remain.
    if (redirect_valid) state_d = (out_d != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= BASE_INSTRUCTION;
      out_q   <= '0;
      cnt_q   <= '0;
      // NOTE: the buffer is reset because inst_* must read zero during reset; large memories normally are not.
      for (int i = 0; i < DEPTH; i++) begin
        pend_q[i] <= '0;
        buf_q[i]  <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        pend_q[i] <= pend_d[i];
        buf_q[i]  <= buf_d[i];
      end
    end
  end

endmodule
